// File: rtl/snn_pkg.sv
// Shared constants, the address-event record and a constant-foldable clog2
// for the spiking-network blocks.
package snn_pkg;

   localparam int AER_NUM_NEURONS = 8;
   localparam int AER_TS_W        = 8;
   localparam int AER_DEPTH       = 8;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result++;
         v = v >> 1;
      end
      return result;
   endfunction

   localparam int AER_ADDR_W = clog2(AER_NUM_NEURONS);

   typedef struct packed {
      logic [AER_ADDR_W-1:0] addr;
      logic [AER_TS_W-1:0]   ts;
   } aer_event_t;

endpackage

// File: rtl/aer_sync_fifo.sv
// First-word-fall-through FIFO: the head entry is visible without a pop and
// reads as zero while empty. Pushes into a full FIFO are ignored.
module aer_sync_fifo
   import snn_pkg::*;
#(
   parameter  int WIDTH = AER_ADDR_W + AER_TS_W,
   parameter  int DEPTH = AER_DEPTH,
   localparam int PTR_W = clog2(DEPTH),
   localparam int CNT_W = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             not_empty,
   output logic             full,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign not_empty = (count_reg != '0);
   assign full      = (count_reg == CNT_W'(DEPTH));
   assign do_push   = push & ~full;
   assign do_pop    = pop & not_empty;
   assign count     = count_reg;
   assign head_data = not_empty ? mem[rd_ptr_reg] : '0;

   // Storage carries no reset so it can map onto distributed RAM.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/spike_aer_encoder.sv
// Timestamps single-cycle spikes, serialises them lowest-index first into
// address-events and buffers them in a FWFT FIFO behind a valid/ready port.
module spike_aer_encoder
   import snn_pkg::*;
#(
   parameter  int NUM_NEURONS = AER_NUM_NEURONS,
   parameter  int TS_W        = AER_TS_W,
   parameter  int DEPTH       = AER_DEPTH,
   localparam int ADDR_W      = clog2(NUM_NEURONS),
   localparam int CNT_W       = clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [NUM_NEURONS-1:0] spike_in,
   output logic                   event_valid,
   input  logic                   event_ready,
   output logic [ADDR_W-1:0]      event_addr,
   output logic [TS_W-1:0]        event_ts,
   output logic [CNT_W-1:0]       fifo_count,
   output logic                   overflow,
   input  logic                   clear_overflow
);

   logic [TS_W-1:0]          ts_reg;
   logic [NUM_NEURONS-1:0]   pending_reg;
   logic [TS_W-1:0]          ts_lat_reg [NUM_NEURONS];
   logic                     overflow_reg;
   logic                     sel_found;
   logic [ADDR_W-1:0]        sel_idx;
   logic [NUM_NEURONS-1:0]   served;
   logic [NUM_NEURONS-1:0]   capture;
   logic                     drop;
   logic                     fifo_full;
   logic                     push;
   logic [ADDR_W+TS_W-1:0]   push_data;
   logic [ADDR_W+TS_W-1:0]   head_data;

   // Scanning downwards lets the lowest set index win.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
         if (pending_reg[i]) begin
            sel_found = 1'b1;
            sel_idx   = ADDR_W'(i);
         end
      end
   end

   assign push      = sel_found & ~fifo_full;
   assign push_data = {sel_idx, ts_lat_reg[sel_idx]};

   always_comb begin
      served = '0;
      if (push) served[sel_idx] = 1'b1;
   end

   // A slot being served this cycle can take a fresh spike without loss.
   assign capture = enable ? (spike_in & (~pending_reg | served)) : '0;
   assign drop    = enable & (|(spike_in & pending_reg & ~served));

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_reg       <= '0;
         pending_reg  <= '0;
         overflow_reg <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) ts_lat_reg[i] <= '0;
      end else begin
         if (enable) ts_reg <= ts_reg + TS_W'(1);
         pending_reg <= (pending_reg & ~served) | capture;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            if (capture[i]) ts_lat_reg[i] <= ts_reg;
         end
         if (drop)                overflow_reg <= 1'b1;
         else if (clear_overflow) overflow_reg <= 1'b0;
      end
   end

   aer_sync_fifo #(
      .WIDTH (ADDR_W + TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (event_ready),
      .head_data (head_data),
      .not_empty (event_valid),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign event_addr = head_data[ADDR_W+TS_W-1:TS_W];
   assign event_ts   = head_data[TS_W-1:0];
   assign overflow   = overflow_reg;

endmodule

// File: doc/spike_aer_encoder.md
Name: spike_aer_encoder

Overview:
Downstream of the LIF neuron array. Collects the single-cycle spike pulses from NUM_NEURONS neurons and timestamps each one on arrival. Encodes each spike as an address-event (neuron index plus timestamp) and buffers the events in a FIFO. Events leave through a valid/ready port to the spike router or host readout.

Parameters:
NUM_NEURONS, 8, number of spike inputs (>=2)
ADDR_W, $clog2(NUM_NEURONS) = 3, event address width (derived, not overridden)
TS_W, 8, timestamp width
DEPTH, 8, FIFO depth in events (power of two)

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = timestamp counter runs and spike_in is sampled
spike_in  input  NUM_NEURONS  one bit per neuron; one-cycle spike pulses
event_valid  output  1  FIFO head holds a valid event
event_ready  input  1  consumer accepts the head event
event_addr  output  ADDR_W  neuron index of the head event
event_ts  output  TS_W  arrival timestamp of the head event
fifo_count  output  $clog2(DEPTH+1)  number of events stored
overflow  output  1  sticky flag: a spike was dropped
clear_overflow  input  1  clears overflow

Behaviour:
- Reset (synchronous, active-high) clears every output and every internal register to 0:
  - ts counter, pending[], ts_lat[], FIFO pointers
  - event_valid, event_addr, event_ts, fifo_count, overflow
- Reset mid-operation discards all pending and buffered events.
- Timestamp counter ts:
  - Increments by 1 every cycle while enable=1.
  - Wraps from 2^TS_W-1 to 0.
  - Holds its value while enable=0.
- Capture, for each neuron i with enable=1 and spike_in[i]=1:
  - If pending[i]=0, or pending[i] is served this cycle: set pending[i]=1 and ts_lat[i]=ts.
  - If pending[i]=1 and not served this cycle: the spike is dropped, ts_lat[i] is kept, and overflow is set.
- With enable=0, spike_in is ignored, but draining of pending events and FIFO pops continue.
- Encode (one event per cycle):
  - The lowest-index set pending bit is selected.
  - If fifo_count < DEPTH, push {i, ts_lat[i]} and clear pending[i] (this is "served").
  - When the FIFO is full, nothing is served and pending bits hold.
  - A full FIFO blocks the push even if a pop happens in the same cycle; no push-through.
- Output FIFO is first-word-fall-through:
  - event_valid = (fifo_count != 0).
  - event_addr and event_ts show the head entry; both are driven to 0 when the FIFO is empty.
  - A pop occurs when event_valid & event_ready.
  - event_addr and event_ts are stable while event_valid=1 and event_ready=0.
- fifo_count update: push and pop in the same cycle leaves the count unchanged; push only adds +1; pop only subtracts 1.
- Latency:
  - A spike sampled at edge E0 is pending after E0, pushed at E1, and shows event_valid=1 after E1.
  - So there are 2 cycles from spike to valid on an idle block.
- Starvation: under sustained spiking, higher-index neurons may wait. No fairness is required, but no event is lost except through overflow.
- overflow is sticky until clear_overflow=1. If a clear and a new drop happen in the same cycle, set wins.

Decomposition:
- snn_pkg holds:
  - TS_W and the default DEPTH
  - aer_event_t = {addr, ts}
  - a clog2 helper function
- One sub-module, aer_sync_fifo:
  - generic first-word-fall-through FIFO of width ADDR_W+TS_W and depth DEPTH
  - count output; push/pop interface
- The capture logic, priority encoder and timestamp counter live in spike_aer_encoder.

Test Plan:
1. Reset, enable=1, single spike_in=8'b0000_0100 in the cycle where ts=5 -> event_valid rises 2 edges later with event_addr=2, event_ts=5; pop with event_ready=1 -> fifo_count returns to 0.
2. spike_in=8'hFF in one cycle at ts=10, event_ready=0 -> over 8 cycles, addresses 0..7 are pushed in order, all with ts=10; fifo_count=8 and overflow=0.
3. FIFO full (8 events), ready=0, then spike_in[3] twice, 3 cycles apart -> the second spike is dropped, overflow=1, and the first ts is kept; clear_overflow=1 -> overflow=0.
4. Backpressure: toggle event_ready on alternate cycles during a burst of 12 spikes -> all 12 events arrive in order, head values stable while stalled, no loss.
5. Run ts through 255->0 with spikes at ts=255 and ts=0 -> events carry 255 then 0; with enable=0 for 4 cycles, spikes are ignored and ts is frozen.
6. Assert reset with 5 events buffered and 2 pending -> the next cycle shows event_valid=0, fifo_count=0, ts=0, overflow=0.
